// File: rtl/sprite_vblank_commit_ctrl_if.sv
// rtl/sprite_vblank_commit_ctrl_if.sv - CPU write port and sprite-engine register bus
interface sprite_vblank_commit_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  out_write_n;
    logic [5:0]  out_address;
    logic [15:0] out_data;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, out_write_n, out_address, out_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, out_write_n, out_address, out_data
    );
endinterface

// File: rtl/sprite_vblank_commit_ctrl.sv
// rtl/sprite_vblank_commit_ctrl.sv - queues sprite register writes and replays them during vblank
module sprite_vblank_commit_ctrl #(
    parameter int DEPTH       = 8,
    parameter int BURST_LIMIT = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    sprite_vblank_commit_ctrl_if.slave   bus,
    input  logic                         vblank,
    input  logic                         commit_en,
    input  logic                         flush,
    input  logic                         clr_ovf,
    output logic [4:0]                   level,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wptr_q, rptr_q;
    logic [4:0]    level_q, level_d;
    logic [7:0]    burst_q, burst_d;
    logic          vb_prev_q;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          ovf_q;
    logic [1:0]    wn_q;
    logic [5:0]    addr_q;
    logic [15:0]   data_q;
    logic [21:0]   mem [DEPTH];

    logic full, empty, push, pop, ovf_evt, vb_rise;

    assign full    = (level_q == 5'(DEPTH));
    assign empty   = (level_q == 5'd0);
    assign push    = bus.wr_valid && !full && !flush;
    assign ovf_evt = bus.wr_valid && full && !flush;
    assign vb_rise = vblank && !vb_prev_q;
    assign level_d = level_q + 5'(push) - 5'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Exit checks use post-pop occupancy so the last pop ends the drain at once.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        done_d  = 1'b0;
        if (pop) begin
            burst_d = burst_q + 8'd1;
        end
        case (state_q)
            IDLE: begin
                if (!empty && commit_en) state_d = ARMED;
            end
            ARMED: begin
                if (!commit_en) begin
                    state_d = IDLE;
                end else if (vb_rise) begin
                    state_d = DRAIN;
                    burst_d = 8'd0;
                end
            end
            DRAIN: begin
                if (level_d == 5'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (!vblank) begin
                    state_d = ARMED;
                end else if (burst_d == 8'(BURST_LIMIT)) begin
                    state_d = ARMED;
                end else if (!commit_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    // Pops are confined to an open window so nothing reaches the engine mid-frame.
    always_comb begin
        pop    = (state_q == DRAIN) && !empty && (burst_q < 8'(BURST_LIMIT))
                 && vblank && commit_en && !flush;
        busy_d = (state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= {bus.wr_addr, bus.wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= 5'd0;
            burst_q   <= 8'd0;
            vb_prev_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wn_q      <= 2'b11;
            addr_q    <= 6'd0;
            data_q    <= 16'd0;
        end else begin
            vb_prev_q <= vblank;
            burst_q   <= burst_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
            wn_q <= pop ? 2'b01 : 2'b11;
            if (pop) begin
                {addr_q, data_q} <= mem[rptr_q];
            end
            if (flush) begin
                level_q <= 5'd0;
                wptr_q  <= '0;
                rptr_q  <= '0;
            end else begin
                level_q <= level_d;
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    assign bus.wr_ready    = !full;
    assign bus.out_write_n = wn_q;
    assign bus.out_address = addr_q;
    assign bus.out_data    = data_q;
    assign level           = level_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign overflow        = ovf_q;
endmodule

// File: tb/tb_sprite_vblank_commit_ctrl.sv
// tb/tb_sprite_vblank_commit_ctrl.sv - scoreboard bench for sprite_vblank_commit_ctrl
module tb_sprite_vblank_commit_ctrl;
    localparam int DEPTH   = 8;
    localparam int BL      = 5;
    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_DRAIN = 2;

    typedef struct packed {
        logic [5:0]  a;
        logic [15:0] d;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vblank = 1'b0;
    logic       commit_en = 1'b0;
    logic       flush = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [4:0] level;
    logic       busy, done, overflow;

    sprite_vblank_commit_ctrl_if bus ();

    sprite_vblank_commit_ctrl #(.DEPTH(DEPTH), .BURST_LIMIT(BL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .vblank(vblank), .commit_en(commit_en),
        .flush(flush), .clr_ovf(clr_ovf), .level(level), .busy(busy), .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    ent_t m_q[$];
    ent_t exp_q[$];
    int   m_mode, m_burst, s0, cyc;
    bit   m_vb_prev, m_ovf, m_done, m_wr_now, rise, popn, full_m;
    int   n_chk = 0, n_fail = 0, wr_cnt = 0, done_cnt = 0, first_wr_cyc = -1;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a queue plus the window rules, advanced once per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_mode = M_IDLE; m_burst = 0; m_vb_prev = 0;
            m_ovf = 0; m_done = 0; m_wr_now = 0;
        end else begin
            s0     = m_q.size();
            rise   = vblank && !m_vb_prev;
            full_m = (s0 == DEPTH);
            popn   = (m_mode == M_DRAIN) && (s0 > 0) && (m_burst < BL)
                     && vblank && commit_en && !flush;
            m_wr_now = popn;
            m_done   = 0;
            if (bus.wr_valid && full_m && !flush) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            if (flush) begin
                m_q.delete();
                m_mode = M_IDLE;
            end else begin
                if (popn) begin
                    exp_q.push_back(m_q.pop_front());
                    m_burst++;
                end
                if (bus.wr_valid && !full_m) m_q.push_back(ent_t'({bus.wr_addr, bus.wr_data}));
                case (m_mode)
                    M_IDLE:  if (s0 != 0 && commit_en) m_mode = M_ARMED;
                    M_ARMED: begin
                        if (!commit_en) m_mode = M_IDLE;
                        else if (rise) begin m_mode = M_DRAIN; m_burst = 0; end
                    end
                    default: begin
                        if (m_q.size() == 0) begin m_mode = M_IDLE; m_done = 1; end
                        else if (!vblank) m_mode = M_ARMED;
                        else if (m_burst == BL) m_mode = M_ARMED;
                        else if (!commit_en) m_mode = M_IDLE;
                    end
                endcase
            end
            m_vb_prev = vblank;
        end
    end

    ent_t e;
    always @(negedge clk) begin
        chk("write_n", int'(bus.out_write_n), m_wr_now ? 1 : 3);
        if (bus.out_write_n == 2'b01) begin
            wr_cnt++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_address", int'(bus.out_address), int'(e.a));
                chk("out_data", int'(bus.out_data), int'(e.d));
            end
        end
        chk("level", int'(level), m_q.size());
        chk("busy", int'(busy), (m_mode == M_DRAIN) ? 1 : 0);
        chk("done", int'(done), int'(m_done));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("wr_ready", int'(bus.wr_ready), (m_q.size() != DEPTH) ? 1 : 0);
        if (done) done_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [5:0] a, input logic [15:0] d);
        bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_writes(input int target, input int budget);
        int k;
        k = 0;
        while (wr_cnt < target && k < budget) begin
            tick();
            k++;
        end
        if (wr_cnt < target) chk("wait_writes_timeout", wr_cnt, target);
    endtask

    int b, d0, set_cyc, vb_cnt;

    initial begin
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        tick(3);
        chk("reset_write_n", int'(bus.out_write_n), 3);
        chk("reset_level", int'(level), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        commit_en = 1'b1;
        tick(2);

        // Three writes committed on a single window, exact cycle placement.
        b = wr_cnt; d0 = done_cnt;
        push(6'h04, 16'h2010); push(6'h06, 16'h00FF); push(6'h08, 16'hF00F);
        tick(3);
        first_wr_cyc = -1;
        set_cyc = cyc;
        vblank = 1'b1;
        tick(12);
        chk("t1_first_write_cycle", first_wr_cyc, set_cyc + 2);
        chk("t1_writes", wr_cnt - b, 3);
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_level", int'(level), 0);
        vblank = 1'b0; tick(3);

        // Burst limit splits eight writes over two windows.
        b = wr_cnt; d0 = done_cnt;
        for (int i = 0; i < 8; i++) push(6'(6'h0A + 2 * i), 16'(16'h1111 * (i + 1)));
        tick(2);
        vblank = 1'b1; tick(100);
        chk("t2_window1_writes", wr_cnt - b, BL);
        chk("t2_window1_done", done_cnt - d0, 0);
        vblank = 1'b0; tick(10);
        vblank = 1'b1; tick(100);
        chk("t2_total_writes", wr_cnt - b, 8);
        chk("t2_done", done_cnt - d0, 1);
        vblank = 1'b0; tick(3);

        // Window closes after two writes of six.
        b = wr_cnt; d0 = done_cnt;
        for (int i = 0; i < 6; i++) push(6'(6'h10 + 2 * i), 16'($urandom));
        tick(2);
        vblank = 1'b1;
        wait_writes(b + 2, 50);
        vblank = 1'b0; tick(3);
        chk("t3_level_after_close", int'(level), 4);
        chk("t3_busy_after_close", int'(busy), 0);
        vblank = 1'b1;
        wait_writes(b + 6, 50);
        tick(3);
        chk("t3_level_end", int'(level), 0);
        chk("t3_done", done_cnt - d0, 1);
        vblank = 1'b0; tick(3);

        // Overflow on the ninth push, then clear.
        for (int i = 0; i < 8; i++) push(6'(6'h04 + 2 * i), 16'(i));
        chk("t4_ready_full", int'(bus.wr_ready), 0);
        push(6'h2C, 16'hDEAD);
        chk("t4_overflow", int'(overflow), 1);
        chk("t4_level_full", int'(level), 8);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("t4_overflow_cleared", int'(overflow), 0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t4_level_flushed", int'(level), 0);
        tick(2);

        // Arming mid-window must wait for the next rising edge.
        vblank = 1'b1; commit_en = 1'b0; tick(2);
        push(6'h20, 16'hA5A5); push(6'h22, 16'h5A5A);
        commit_en = 1'b1;
        b = wr_cnt;
        tick(15);
        chk("t5_no_midwindow_write", wr_cnt - b, 0);
        vblank = 1'b0; tick(3);
        vblank = 1'b1;
        wait_writes(b + 2, 20);
        tick(3);
        chk("t5_level", int'(level), 0);
        vblank = 1'b0; tick(3);

        // Asynchronous reset during a drain.
        b = wr_cnt;
        for (int i = 0; i < 6; i++) push(6'(6'h04 + 2 * i), 16'($urandom));
        tick(2);
        vblank = 1'b1;
        wait_writes(b + 1, 30);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_write_n", int'(bus.out_write_n), 3);
        chk("t6_rst_level", int'(level), 0);
        chk("t6_rst_busy", int'(busy), 0);
        tick(2);
        rst_n = 1'b1; vblank = 1'b0;
        tick(3);

        // Flush during a drain.
        for (int i = 0; i < 6; i++) push(6'(6'h04 + 2 * i), 16'($urandom));
        tick(2);
        b = wr_cnt;
        vblank = 1'b1;
        wait_writes(b + 2, 30);
        b = wr_cnt;
        flush = 1'b1; tick(); flush = 1'b0;
        tick(10);
        chk("t6_flush_extra_writes_le1", (wr_cnt - b <= 1) ? 1 : 0, 1);
        chk("t6_flush_level", int'(level), 0);
        chk("t6_flush_busy", int'(busy), 0);
        vblank = 1'b0; tick(3);

        // Randomized traffic against the model.
        vb_cnt = 10;
        for (int i = 0; i < 3000; i++) begin
            bus.wr_valid = ($urandom_range(0, 3) == 0);
            bus.wr_addr  = 6'($urandom);
            bus.wr_data  = 16'($urandom);
            if (vb_cnt == 0) begin
                vblank = !vblank;
                vb_cnt = vblank ? int'($urandom_range(3, 30)) : int'($urandom_range(5, 40));
            end else begin
                vb_cnt--;
            end
            commit_en = ($urandom_range(0, 31) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            clr_ovf   = ($urandom_range(0, 49) == 0);
            tick();
        end
        bus.wr_valid = 1'b0; flush = 1'b0; clr_ovf = 1'b0; vblank = 1'b0;
        tick(5);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_vblank_commit_ctrl.md
Name: sprite_vblank_commit_ctrl

Overview:
- Queues CPU writes to the sprite engine's 16-bit config registers (sprite position/bitmap window, 0x04-0x2C) and replays them onto the engine's register bus only inside vertical blanking, so sprite updates never tear mid-frame.
- Sits between the TinyQV peripheral write decode and the sprite engine's address/data_in/data_write_n inputs.
- Sequences when the engine is configured: one write per clock, FIFO order, bounded per blanking window.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- BURST_LIMIT, 16, maximum writes issued per vblank window; 1..255.

Ports:
- clk  in  1  project clock.
- rst_n  in  1  reset; asynchronous, active-low.
- wr_valid  in  1  CPU write request.
- wr_ready  out  1  FIFO can accept; equals !full.
- wr_addr  in  6  target register address.
- wr_data  in  16  target register data.
- vblank  in  1  level, high during vertical blanking; synchronous to clk.
- commit_en  in  1  enables draining.
- flush  in  1  one-cycle pulse; discards queued entries.
- clr_ovf  in  1  one-cycle pulse; clears overflow.
- out_write_n  out  2  engine write strobe: 2'b01 = 16-bit write, 2'b11 = idle.
- out_address  out  6  engine address.
- out_data  out  16  engine data.
- level  out  5  current FIFO occupancy, 0..DEPTH.
- busy  out  1  high in DRAIN.
- done  out  1  one-cycle pulse when a drain empties the FIFO.
- overflow  out  1  sticky; set when a write is attempted while full.

Behaviour:
- Reset values (async, rst_n low):
  - out_write_n = 11; out_address = 0; out_data = 0.
  - level = 0; busy = 0; done = 0; overflow = 0.
  - FSM = IDLE; vb_d = 0; burst counter = 0.
- FIFO:
  - Push when wr_valid && wr_ready.
  - wr_valid while full: entry dropped, overflow <= 1.
  - Push and pop in the same cycle are both legal; level is unchanged.
  - Read/write pointers wrap modulo DEPTH.
- vb_rise = vblank && !vb_d, where vb_d is vblank registered each cycle.
- FSM states and transitions:
  - IDLE: go to ARMED when level != 0 && commit_en.
  - ARMED:
    - On vb_rise && commit_en, go to DRAIN and clear the burst counter.
    - If ARMED is entered while vblank is already high, wait for the next vb_rise; never start mid-window.
    - commit_en low: go to IDLE.
  - DRAIN, each cycle:
    - Pop the head entry if the FIFO is non-empty and the burst counter < BURST_LIMIT; increment the burst counter.
    - Exit DRAIN on the first of the following conditions:
      - FIFO empty (including after popping the last entry): done = 1 next cycle, go to IDLE.
      - vblank low: go to ARMED.
      - burst counter == BURST_LIMIT: go to ARMED.
      - commit_en low: go to IDLE; entries retained.
    - Pushes during DRAIN are accepted and are drained in the same window, in FIFO order.
- Output timing:
  - An entry popped in cycle N drives out_write_n = 01 with its address/data in cycle N+1, for exactly one cycle. Registered outputs, latency 1.
  - In all other cycles out_write_n = 11, and out_address/out_data hold their last values.
- flush:
  - Highest priority: level <= 0, pointers reset, FSM <= IDLE, and no pop that cycle.
  - A simultaneous push is discarded and does not set overflow.
  - A write already registered on out_* still completes.
- clr_ovf and a new overflow event in the same cycle: overflow stays 1.
- done and busy are registered.
- busy = 1 exactly while FSM = DRAIN.

Test Plan:
- Queue 3 writes while vblank = 0 and commit_en = 1, then raise vblank -> out_write_n = 01 on cycles vb_rise+2 .. vb_rise+4 with {04,0x2010}, {06,0x00FF}, {08,0xF00F} in order; done pulses once; level = 0.
- Queue 8 writes with BURST_LIMIT = 5 and a vblank of 100 cycles -> 5 writes issued in the first window and 3 in the next; done only after the 8th write.
- Drop vblank after 2 writes of 6 queued -> FSM = ARMED and level = 4; the remaining 4 issue on the next vb_rise.
- With DEPTH = 8, push 9 writes -> wr_ready = 0 after the 8th; the 9th is dropped and overflow = 1. Pulse clr_ovf -> overflow = 0.
- Raise commit_en while vblank is already high -> no writes until vblank falls and rises again.
- Assert rst_n low mid-DRAIN asynchronously -> out_write_n = 11, level = 0, busy = 0 immediately. Separately, pulse flush mid-DRAIN -> at most one further write, then IDLE with level = 0.
